instr_fetch_unit: RTL and testbench

//  Producer side of the 16-bit op bus consumed by the instruction decode / data-selector control.

---
 rtl/isa_pkg.sv | 31 +++
 rtl/ifu_pc_reg.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: shared op-bus field constants and helpers for the 16-bit ISA.
// Used by the fetch unit (HLT detection) and by decode-side consumers.
package isa_pkg;

  // Major opcode field op[15:14]
  localparam logic [1:0] OPC_ALU = 2'b11;
  localparam logic [1:0] OPC_BR  = 2'b10;
  localparam logic [1:0] OPC_LD  = 2'b00;
  localparam logic [1:0] OPC_ST  = 2'b01;

  // Branch condition "always" in op[13:11]
  localparam logic [2:0] BR_COND = 3'b111;

  // ALU sub-opcodes in op[7:4]
  localparam logic [3:0] SUB_OUT = 4'b1100;
  localparam logic [3:0] SUB_HLT = 4'b1111;

  // Field slice positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 14;
  localparam int BRC_MSB = 13;
  localparam int BRC_LSB = 11;
  localparam int SUB_MSB = 7;
  localparam int SUB_LSB = 4;

  // True when the word is the HLT encoding (ALU major opcode with HLT sub-op).
  function automatic logic is_hlt(input logic [15:0] op);
    return (op[OPC_MSB:OPC_LSB] == OPC_ALU) && (op[SUB_MSB:SUB_LSB] == SUB_HLT);
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter for the fetch unit.
// Async reset to RESET_PC; a redirect load wins over a sequential increment.
// Increment wraps modulo 2^ADDR_W without any carry indication.
module ifu_pc_reg #(
  parameter int                 ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: load has priority, then increment, otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit instruction words at PC and presents them
// on the op bus under a valid/ready handshake, with branch redirect.
// Optional feature macro IFU_HALT_DETECT_EN: when defined, the transfer of a
// HLT word stops fetching until reset and raises halted.
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int                 ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              imem_valid,
  output logic [15:0]       op_out,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] op_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4,
    HALT  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              op_valid_q, op_valid_d;
  logic [15:0]       op_out_q, op_out_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  logic              halted_q, halted_d;
  logic              pc_load_s;
  logic              pc_inc_s;
  logic [ADDR_W-1:0] pc_s;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load_s),
    .load_val_i (redirect_pc),
    .inc_i      (pc_inc_s),
    .pc_o       (pc_s)
  );

  // Next-state, PC control and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    pc_load_s = 1'b0;
    pc_inc_s  = 1'b0;
    op_out_d  = op_out_q;
    op_pc_d   = op_pc_q;
    halted_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_load_s = 1'b1;
          state_d   = run ? REQ : IDLE;
        end else if (run) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A request already left this cycle; a redirect must drain its reply.
        if (redirect) begin
          pc_load_s = 1'b1;
          state_d   = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_load_s = 1'b1;
          state_d   = imem_valid ? REQ : DRAIN;
        end else if (imem_valid) begin
          op_out_d = imem_data;
          op_pc_d  = pc_s;
          pc_inc_s = 1'b1;
          state_d  = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        // Redirect discards the held op even if it would transfer this cycle.
        if (redirect) begin
          pc_load_s = 1'b1;
          state_d   = REQ;
        end else if (op_ready) begin
`ifdef IFU_HALT_DETECT_EN
          if (is_hlt(op_out_q)) begin
            state_d = HALT;
          end else if (run) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
`else
          if (run) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_load_s = 1'b1;
          state_d   = imem_valid ? REQ : DRAIN;
        end else if (imem_valid) begin
          state_d = REQ;
        end else begin
          state_d = DRAIN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d      = (state_d == REQ);
    op_valid_d = (state_d == HOLD);
`ifdef IFU_HALT_DETECT_EN
    halted_d   = (state_d == HALT);
`else
    halted_d   = 1'b0;
`endif
  end

  // State and output registers; reset drops any in-flight fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      op_valid_q <= 1'b0;
      op_out_q   <= 16'h0000;
      op_pc_q    <= RESET_PC;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      op_valid_q <= op_valid_d;
      op_out_q   <= op_out_d;
      op_pc_q    <= op_pc_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_s;
  assign op_out    = op_out_q;
  assign op_valid  = op_valid_q;
  assign op_pc     = op_pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
// Two instances: dut (RESET_PC=0) and dut_w (RESET_PC=12'hFFF, wrap case).
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        run = 1'b0, op_ready = 1'b0, redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;
  logic        imem_req, op_valid, halted;
  logic [11:0] imem_addr, op_pc;
  logic [15:0] op_out;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_valid = 1'b0;

  logic        run_w = 1'b0, op_ready_w = 1'b0, redirect_w = 1'b0;
  logic [11:0] redirect_pc_w = 12'h000;
  logic        imem_req_w, op_valid_w, halted_w;
  logic [11:0] imem_addr_w, op_pc_w;
  logic [15:0] op_out_w;
  logic [15:0] imem_data_w = 16'h0000;
  logic        imem_valid_w = 1'b0;

  int checks = 0;
  int fails  = 0;
  int lat    = 1;

  logic [15:0] mem [0:4095];
  int          cnt = 0, cnt_w = 0;
  logic [11:0] pend = 12'h000, pend_w = 12'h000;

  instr_fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid), .op_out(op_out), .op_valid(op_valid),
    .op_ready(op_ready), .op_pc(op_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(12), .RESET_PC(12'hFFF)) dut_w (
    .clk(clk), .rst(rst), .run(run_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_data(imem_data_w), .imem_valid(imem_valid_w), .op_out(op_out_w), .op_valid(op_valid_w),
    .op_ready(op_ready_w), .op_pc(op_pc_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .halted(halted_w)
  );

  // Memory model for dut: reply 'lat' cycles after the request; not reset by rst.
  always @(posedge clk) begin
    imem_valid <= 1'b0;
    if (cnt > 0) begin
      if (cnt == 1) begin
        imem_valid <= 1'b1;
        imem_data  <= mem[pend];
      end
      cnt <= cnt - 1;
    end
    if (imem_req) begin
      if (lat == 1) begin
        imem_valid <= 1'b1;
        imem_data  <= mem[imem_addr];
      end else begin
        pend <= imem_addr;
        cnt  <= lat - 1;
      end
    end
  end

  // Memory model for dut_w: fixed one-cycle latency.
  always @(posedge clk) begin
    imem_valid_w <= 1'b0;
    if (imem_req_w) begin
      imem_valid_w <= 1'b1;
      imem_data_w  <= mem[imem_addr_w];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; run_w = 1'b0; op_ready = 1'b0; op_ready_w = 1'b0;
    redirect = 1'b0; redirect_pc = 12'h000;
    repeat (4) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_imem_req got=%0h exp=0", imem_req); end
    checks++; if (imem_addr !== 12'h000) begin fails++; $display("FAIL reset_imem_addr got=%0h exp=0", imem_addr); end
    checks++; if (op_out !== 16'h0000) begin fails++; $display("FAIL reset_op_out got=%0h exp=0", op_out); end
    checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL reset_op_valid got=%0h exp=0", op_valid); end
    checks++; if (op_pc !== 12'h000) begin fails++; $display("FAIL reset_op_pc got=%0h exp=0", op_pc); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got=%0h exp=0", halted); end
    checks++; if (op_pc_w !== 12'hFFF) begin fails++; $display("FAIL reset_w_op_pc got=%0h exp=fff", op_pc_w); end
    checks++; if (imem_addr_w !== 12'hFFF) begin fails++; $display("FAIL reset_w_imem_addr got=%0h exp=fff", imem_addr_w); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_op [0:3];
    int n;
    exp_op[0] = 16'hC0C0; exp_op[1] = 16'h0001; exp_op[2] = 16'h4002; exp_op[3] = 16'hB803;
    do_reset();
    lat = 1; run = 1'b1; op_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!op_valid && n < 20) begin step(); n++; end
      checks++; if (op_valid !== 1'b1) begin fails++; $display("FAIL seq_timeout op=%0d got=%0h exp=1", k, op_valid); end
      checks++; if (op_out !== exp_op[k]) begin fails++; $display("FAIL seq_op_out op=%0d got=%0h exp=%0h", k, op_out, exp_op[k]); end
      checks++; if (op_pc !== 12'(k)) begin fails++; $display("FAIL seq_op_pc op=%0d got=%0h exp=%0h", k, op_pc, k); end
      if (k > 0) begin
        checks++; if (n != 2) begin fails++; $display("FAIL seq_gap op=%0d got=%0d exp=2", k, n); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    lat = 1; run = 1'b1; op_ready = 1'b1;
    n = 0; while (!op_valid && n < 20) begin step(); n++; end
    step();
    op_ready = 1'b0;
    n = 0; while (!op_valid && n < 20) begin step(); n++; end
    checks++; if (op_out !== 16'h0001) begin fails++; $display("FAIL bp_first got=%0h exp=0001", op_out); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (op_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cyc=%0d got=%0h exp=1", c, op_valid); end
      checks++; if (op_out !== 16'h0001) begin fails++; $display("FAIL bp_op_out cyc=%0d got=%0h exp=0001", c, op_out); end
      checks++; if (op_pc !== 12'h001) begin fails++; $display("FAIL bp_op_pc cyc=%0d got=%0h exp=001", c, op_pc); end
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_no_req cyc=%0d got=%0h exp=0", c, imem_req); end
    end
    op_ready = 1'b1;
    step();
    checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL bp_transfer got=%0h exp=0", op_valid); end
    n = 0; while (!op_valid && n < 20) begin step(); n++; end
    checks++; if (op_pc !== 12'h002) begin fails++; $display("FAIL bp_next_pc got=%0h exp=002", op_pc); end
  endtask

  task automatic test_redirect_wait();
    int n;
    do_reset();
    lat = 3; run = 1'b1; op_ready = 1'b1;
    n = 0; while (!imem_req && n < 20) begin step(); n++; end
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rdw_req_timeout got=%0h exp=1", imem_req); end
    step();
    redirect = 1'b1; redirect_pc = 12'h100;
    step();
    redirect = 1'b0;
    checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL rdw_valid got=%0h exp=0", op_valid); end
    n = 0; while (!op_valid && n < 30) begin step(); n++; end
    checks++; if (op_pc !== 12'h100) begin fails++; $display("FAIL rdw_op_pc got=%0h exp=100", op_pc); end
    checks++; if (op_out !== 16'h1234) begin fails++; $display("FAIL rdw_op_out got=%0h exp=1234", op_out); end
    lat = 1;
  endtask

  task automatic test_redirect_hold();
    int n;
    do_reset();
    lat = 1; run = 1'b1; op_ready = 1'b0;
    n = 0; while (!op_valid && n < 20) begin step(); n++; end
    op_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'h200;
    step();
    redirect = 1'b0;
    checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL rdh_valid got=%0h exp=0", op_valid); end
    n = 0; while (!op_valid && n < 20) begin step(); n++; end
    checks++; if (op_pc !== 12'h200) begin fails++; $display("FAIL rdh_op_pc got=%0h exp=200", op_pc); end
    checks++; if (op_out !== 16'h5678) begin fails++; $display("FAIL rdh_op_out got=%0h exp=5678", op_out); end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_pc [0:1];
    logic [15:0] exp_op [0:1];
    int n;
    exp_pc[0] = 12'hFFF; exp_pc[1] = 12'h000;
    exp_op[0] = 16'hABCD; exp_op[1] = 16'hC0C0;
    do_reset();
    run_w = 1'b1; op_ready_w = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0; while (!op_valid_w && n < 20) begin step(); n++; end
      checks++; if (op_pc_w !== exp_pc[k]) begin fails++; $display("FAIL wrap_op_pc op=%0d got=%0h exp=%0h", k, op_pc_w, exp_pc[k]); end
      checks++; if (op_out_w !== exp_op[k]) begin fails++; $display("FAIL wrap_op_out op=%0d got=%0h exp=%0h", k, op_out_w, exp_op[k]); end
      step();
    end
    run_w = 1'b0;
  endtask

  task automatic test_halt();
    int n;
    logic seen_req;
    mem[2] = 16'hC0F0;
    do_reset();
    lat = 1; run = 1'b1; op_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0; while (!op_valid && n < 20) begin step(); n++; end
      checks++; if (op_pc !== 12'(k)) begin fails++; $display("FAIL halt_op_pc op=%0d got=%0h exp=%0h", k, op_pc, k); end
      step();
    end
`ifdef IFU_HALT_DETECT_EN
    checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag got=%0h exp=1", halted); end
    seen_req = 1'b0;
    redirect = 1'b1; redirect_pc = 12'h300;
    for (int c = 0; c < 10; c++) begin
      step();
      redirect = 1'b0;
      seen_req = seen_req | imem_req | op_valid;
    end
    checks++; if (seen_req !== 1'b0) begin fails++; $display("FAIL halt_no_fetch got=%0h exp=0", seen_req); end
    checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_sticky got=%0h exp=1", halted); end
`else
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_flag got=%0h exp=0", halted); end
    seen_req = 1'b0;
    n = 0; while (!imem_req && n < 20) begin step(); n++; end
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL halt_continue got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 12'h003) begin fails++; $display("FAIL halt_next_addr got=%0h exp=003", imem_addr); end
`endif
    mem[2] = 16'h4002;
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    lat = 3; run = 1'b1; op_ready = 1'b1;
    n = 0; while (!op_valid && n < 20) begin step(); n++; end
    step();
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL ar_req got=%0h exp=1", imem_req); end
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (op_out !== 16'h0000) begin fails++; $display("FAIL ar_op_out got=%0h exp=0", op_out); end
    checks++; if (imem_addr !== 12'h000) begin fails++; $display("FAIL ar_imem_addr got=%0h exp=0", imem_addr); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL ar_imem_req got=%0h exp=0", imem_req); end
    checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL ar_op_valid got=%0h exp=0", op_valid); end
    run = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (op_valid !== 1'b0) begin fails++; $display("FAIL ar_stale_valid cyc=%0d got=%0h exp=0", c, op_valid); end
    end
    lat = 1; run = 1'b1;
    n = 0; while (!op_valid && n < 20) begin step(); n++; end
    checks++; if (op_pc !== 12'h000) begin fails++; $display("FAIL ar_restart_pc got=%0h exp=0", op_pc); end
    checks++; if (op_out !== 16'hC0C0) begin fails++; $display("FAIL ar_restart_op got=%0h exp=c0c0", op_out); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
    mem[0] = 16'hC0C0; mem[1] = 16'h0001; mem[2] = 16'h4002; mem[3] = 16'hB803;
    mem[12'h100] = 16'h1234; mem[12'h200] = 16'h5678; mem[12'hFFF] = 16'hABCD;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
